linear_led_driver: RTL and testbench
====================================

# linear_led_driver

Downstream stage of the linear visualizer: accepts one frame of per-bin colours and per-bin LED counts, expands it into exactly `LEDS` pixels, and serializes them onto a single WS2812-style one-wire data line. It then holds the line low for the latch interval. The block sits between the visualizer output registers and the strip pin.

## Interface
- `LEDS`, 50: physical pixels on the strip; every frame emits exactly this many.
- `BIN_QTY`, 12: number of colour bins.
- `T0H`, 4: high cycles for a 0 bit.
- `T0L`, 9: low cycles for a 0 bit.
- `T1H`, 8: high cycles for a 1 bit.
- `T1L`, 5: low cycles for a 1 bit.
- `RESET_CYCLES`, 800: low cycles after the last bit (latch interval).

Ports:
- `clk`  in  1: single clock. Defaults assume 10 MHz.
- `rst`  in  1: synchronous, active-high reset.
- `rgb`  in  [BIN_QTY-1:0][23:0]: bin colours. R=[23:16], G=[15:8], B=[7:0].
- `LEDCounts`  in  [BIN_QTY-1:0][$clog2(LEDS)-1:0]: pixels requested per bin.
- `data_v`  in  1: `rgb` and `LEDCounts` are valid this cycle.
- `ledData`  out  1: serial line to the strip.
- `busy`  out  1: frame in progress; `data_v` is ignored while this is high.
- `frameDone`  out  1: one-cycle pulse when the latch interval ends.

## Operation
- States: IDLE, LOAD, SEND_HIGH, SEND_LOW, LATCH.
- **IDLE**
  - `data_v`=1 latches `rgb` and `LEDCounts` into internal registers and goes to LOAD.
  - `data_v` is sampled only in IDLE; there is no queueing.
- **LOAD** (one cycle)
  - Registers prefix sums `cum[i] = sum(LEDCounts[0..i])`.
  - Width is `$clog2(BIN_QTY*(LEDS-1)+1)`, 10 bits at the defaults; no overflow is possible.
  - Clears the pixel counter `p` and the bit counter, then goes to SEND_HIGH.
- **Pixel colour**
  - Pixel `p` takes `rgb[i]` for the smallest `i` with `p < cum[i]`.
  - If no bin matches, the pixel is black (24'h0).
  - Zero-count bins are skipped with no gap cycles.
  - If the counts sum to more than `LEDS`, trailing bins are truncated.
  - If they sum to less than `LEDS`, the remaining pixels are padded black.
- **Bit order**
  - Pixel 0 first.
  - Within a pixel: G7..G0, R7..R0, B7..B0, i.e. word `{G,R,B}` MSB first.
- **SEND_HIGH**
  - `ledData`=1 for `T1H` cycles (bit=1) or `T0H` cycles (bit=0), then SEND_LOW.
- **SEND_LOW**
  - `ledData`=0 for `T1L` or `T0L` cycles.
  - Then the next bit, or the next pixel after bit 23.
  - After bit 23 of pixel `LEDS-1`, goes to LATCH.
- **LATCH**
  - `ledData`=0 for `RESET_CYCLES` cycles.
  - Then IDLE with `frameDone`=1 for that single cycle.
- **Reset**
  - All outputs go to 0 in the cycle after `rst` is sampled high: `ledData`=0, `busy`=0, `frameDone`=0.
  - State returns to IDLE; latched colours, counts, prefix sums and counters clear.
  - Reset mid-frame aborts immediately. The partial frame is not resumed.

## Timing
- All outputs are registered.
- `data_v` sampled in IDLE at edge k: `busy`=1 from cycle k+1 (LOAD); `ledData` rises at cycle k+2.
- `busy`=1 in LOAD, SEND_HIGH, SEND_LOW and LATCH; `busy`=0 in the `frameDone` cycle.
- Bit period is `T1H+T1L` or `T0H+T0L`; both are 13 cycles at the defaults, so a bit is 1.3 µs.
- Full frame at defaults:
  - bits occupy cycles k+2 .. k+15601 (24·50·13 = 15600 cycles);
  - LATCH occupies cycles k+15602 .. k+16401;
  - `frameDone` at cycle k+16402.
- `data_v`=1 in the `frameDone` cycle is accepted, since the state is IDLE. Back-to-back frames have no extra gap.
- `data_v` while `busy`=1 is dropped without any indication.

## Structure
- Add to the CCHW package:
  - the state enum typedef;
  - default WS2812 timing constants;
  - a function returning the `{G,R,B}` word from a 24-bit `rgb`.
- `LEDS` and `BIN_QTY` defaults match the visualizer constants.
- One natural sub-module, `ws2812_bit_tx`:
  - input: 24-bit word with start/ready handshake;
  - output: `ledData` and `done`;
  - it owns SEND_HIGH/SEND_LOW and the bit counter.
- The parent owns latching, prefix sums, pixel selection and LATCH.

## Test plan
- **Reset:** `rst`=1 for 10 cycles with `data_v`=1 → `ledData`, `busy`, `frameDone` all 0; no activity for 20 cycles after release.
- **Single bin:** `LEDCounts[0]`=50, `rgb[0]`=24'hFF0000, others 0 → 50 pixels, each decoding to word 24'h00FF00 (bits 8–15 high); `frameDone` at k+16402.
- **Underfill:** `LEDCounts[3]`=10, `rgb[3]`=24'h0000FF, others 0 → pixels 0–9 decode to 24'h0000FF; pixels 10–49 decode to 0.
- **Overfill:** all `LEDCounts`=10, `rgb[i]`=i → pixels 10i..10i+9 carry colour i for i=0..4; bins 5–11 are absent; exactly 1200 bits.
- **Bit timing:** high widths are exactly 8 cycles (1) and 4 cycles (0); every bit period is 13; the latch low is exactly 800 cycles.
- **Protocol edges:**
  - `data_v` pulsed mid-frame → ignored, frame unchanged.
  - `data_v` in the `frameDone` cycle → new `ledData` rise 2 cycles later.
  - `rst` at bit 600 → `ledData`=0 and `busy`=0 next cycle.

Source files
------------

// File: rtl/linear_led_driver_pkg.sv
// linear_led_driver_pkg: state encoding, WS2812 timing defaults and pixel word packing
// shared by the LED driver and its bit serializer.
package linear_led_driver_pkg;
   localparam int DEF_LEDS = 50;
   localparam int DEF_BIN_QTY = 12;
   localparam int DEF_T0H = 4;
   localparam int DEF_T0L = 9;
   localparam int DEF_T1H = 8;
   localparam int DEF_T1L = 5;
   localparam int DEF_RESET_CYCLES = 800;
   typedef enum logic [2:0] {IDLE, LOAD, SEND_HIGH, SEND_LOW, LATCH} state_t;
   function automatic logic [23:0] grb(input logic [23:0] c);
      return {c[15:8], c[23:16], c[7:0]};
   endfunction
endpackage

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx: shifts a 24-bit word MSB first as WS2812 high/low pulses; ready rises
// in the last low cycle of bit 23 so the next word follows with no gap.
module ws2812_bit_tx
   import linear_led_driver_pkg::*;
#(
   parameter int T0H = DEF_T0H,
   parameter int T0L = DEF_T0L,
   parameter int T1H = DEF_T1H,
   parameter int T1L = DEF_T1L
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [23:0] word,
   output logic        ready,
   output logic        done,
   output logic        ledData
);
   localparam logic [7:0] H0 = 8'(T0H - 1);
   localparam logic [7:0] L0 = 8'(T0L - 1);
   localparam logic [7:0] H1 = 8'(T1H - 1);
   localparam logic [7:0] L1 = 8'(T1L - 1);
   state_t state, nxt;
   logic [23:0] sh;
   logic [4:0] bit_i;
   logic [7:0] cnt;
   logic hi_last, lo_last, led_d;
   always_comb begin
      hi_last = cnt == (sh[23] ? H1 : H0);
      lo_last = cnt == (sh[23] ? L1 : L0);
      done = state == SEND_LOW && lo_last && bit_i == 5'd23;
      ready = state == IDLE || done;
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = start ? SEND_HIGH : IDLE;
         SEND_HIGH: nxt = hi_last ? SEND_LOW : SEND_HIGH;
         SEND_LOW:  nxt = !lo_last ? SEND_LOW : (bit_i != 5'd23 || start) ? SEND_HIGH : IDLE;
         default:   nxt = IDLE;
      endcase
   end
   always_comb led_d = nxt == SEND_HIGH;
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         ledData <= 1'b0;
         cnt <= '0;
         sh <= '0;
         bit_i <= '0;
      end else begin
         state <= nxt;
         ledData <= led_d;
         cnt <= (state == nxt && state != IDLE) ? cnt + 8'd1 : 8'd0;
         if (start && ready) begin
            sh <= word;
            bit_i <= '0;
         end else if (state == SEND_LOW && lo_last) begin
            sh <= {sh[22:0], 1'b0};
            bit_i <= bit_i + 5'd1;
         end
      end
endmodule

// File: rtl/linear_led_driver.sv
// linear_led_driver: latches one frame of bin colours and counts, expands it to LEDS pixels
// and streams them through ws2812_bit_tx, then holds the line low for the latch interval.
module linear_led_driver
   import linear_led_driver_pkg::*;
#(
   parameter int LEDS = DEF_LEDS,
   parameter int BIN_QTY = DEF_BIN_QTY,
   parameter int T0H = DEF_T0H,
   parameter int T0L = DEF_T0L,
   parameter int T1H = DEF_T1H,
   parameter int T1L = DEF_T1L,
   parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [BIN_QTY-1:0][23:0]              rgb,
   input  logic [BIN_QTY-1:0][$clog2(LEDS)-1:0]  LEDCounts,
   input  logic                                  data_v,
   output logic                                  ledData,
   output logic                                  busy,
   output logic                                  frameDone
);
   localparam int NW = $clog2(LEDS);
   localparam int CW = $clog2(BIN_QTY * (LEDS - 1) + 1);
   localparam int PW = $clog2(LEDS + 1);
   localparam int RW = $clog2(RESET_CYCLES);
   localparam logic [PW-1:0] LAST_P = PW'(LEDS);
   localparam logic [RW-1:0] LAST_R = RW'(RESET_CYCLES - 1);
   state_t state, nxt;
   logic [BIN_QTY-1:0][23:0] rgb_r;
   logic [BIN_QTY-1:0][NW-1:0] cnt_r;
   logic [BIN_QTY-1:0][CW-1:0] cum, cum_d, sel;
   logic [CW-1:0] acc;
   logic [PW-1:0] p;
   logic [RW-1:0] lat;
   logic [23:0] col;
   logic start, ready, done, busy_d, done_d;
   always_comb begin
      acc = '0;
      cum_d = '0;
      for (int i = 0; i < BIN_QTY; i++) begin
         acc = acc + CW'(cnt_r[i]);
         cum_d[i] = acc;
      end
   end
   // Pixel 0 is handed over in LOAD while cum is still being written, so it reads the sums directly.
   always_comb begin
      sel = state == LOAD ? cum_d : cum;
      col = '0;
      for (int i = BIN_QTY - 1; i >= 0; i--)
         if (CW'(p) < sel[i]) col = rgb_r[i];
   end
   assign start = state == LOAD || (state == SEND_HIGH && p != LAST_P);
   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = data_v ? LOAD : IDLE;
         LOAD:      nxt = SEND_HIGH;
         SEND_HIGH: nxt = (done && p == LAST_P) ? LATCH : SEND_HIGH;
         LATCH:     nxt = lat == LAST_R ? IDLE : LATCH;
         default:   nxt = IDLE;
      endcase
   end
   always_comb begin
      busy_d = nxt != IDLE;
      done_d = state == LATCH && nxt == IDLE;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         busy <= 1'b0;
         frameDone <= 1'b0;
         rgb_r <= '0;
         cnt_r <= '0;
         cum <= '0;
         p <= '0;
         lat <= '0;
      end else begin
         state <= nxt;
         busy <= busy_d;
         frameDone <= done_d;
         if (state == IDLE && data_v) begin
            rgb_r <= rgb;
            cnt_r <= LEDCounts;
         end
         if (state == LOAD) cum <= cum_d;
         p <= state == IDLE ? '0 : (start && ready) ? p + PW'(1) : p;
         lat <= state == LATCH ? lat + RW'(1) : '0;
      end
   ws2812_bit_tx #(.T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L)) u_tx (
      .clk(clk),
      .rst(rst),
      .start(start),
      .word(grb(col)),
      .ready(ready),
      .done(done),
      .ledData(ledData)
   );
endmodule

// File: tb/tb_linear_led_driver.sv
// tb_linear_led_driver: directed frames decoded from the serial line and compared with
// hand-computed pixel words, pulse widths and frame timing.
module tb_linear_led_driver;
   localparam int T0H = 4;
   localparam int T1H = 8;
   localparam int BITS = 1200;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic data_v = 1'b0;
   logic [11:0][23:0] rgb_in = '0;
   logic [11:0][5:0] counts = '0;
   logic ledData, busy, frameDone;
   int total = 0;
   int passed = 0;
   int nbits, bad_hi, bad_per, first_rise, last_rise, done_cyc, hi_len, n;
   logic prev, busy1;
   logic [23:0] pix [50];

   linear_led_driver dut (
      .clk(clk),
      .rst(rst),
      .rgb(rgb_in),
      .LEDCounts(counts),
      .data_v(data_v),
      .ledData(ledData),
      .busy(busy),
      .frameDone(frameDone)
   );

   always #5 clk = ~clk;

   task automatic set_overfill();
      for (int i = 0; i < 12; i++) begin
         rgb_in[i] = 24'(i);
         counts[i] = 6'd10;
      end
   endtask

   // Starts a frame on the next edge and decodes the line until frameDone or timeout.
   task automatic run_frame(input int glitch_at);
      data_v = 1'b1;
      nbits = 0; bad_hi = 0; bad_per = 0; first_rise = -1; last_rise = -1;
      done_cyc = -1; hi_len = 0; prev = 1'b0; busy1 = 1'b0;
      for (int i = 0; i < 50; i++) pix[i] = '0;
      for (int cyc = 1; cyc <= 17000 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         data_v = cyc == glitch_at;
         if (cyc == glitch_at) set_overfill();
         if (cyc == 1) busy1 = busy;
         if (ledData && !prev) begin
            if (first_rise < 0) first_rise = cyc;
            else if (cyc - last_rise != 13) bad_per++;
            last_rise = cyc;
         end
         if (ledData) hi_len++;
         if (!ledData && prev) begin
            if (hi_len != T0H && hi_len != T1H) bad_hi++;
            if (nbits < BITS) pix[nbits / 24] = {pix[nbits / 24][22:0], hi_len == T1H};
            nbits++;
            hi_len = 0;
         end
         prev = ledData;
         if (frameDone) done_cyc = cyc;
      end
      data_v = 1'b0;
   endtask

   task automatic test_reset();
      logic act;
      rst = 1'b1; data_v = 1'b1; rgb_in[0] = 24'hFFFFFF; counts[0] = 6'd50;
      repeat (10) @(negedge clk);
      total++; if (ledData !== 1'b0) $display("FAIL reset_led: got %b want 0", ledData); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (frameDone !== 1'b0) $display("FAIL reset_done: got %b want 0", frameDone); else passed++;
      rst = 1'b0; data_v = 1'b0;
      act = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (ledData !== 1'b0 || busy !== 1'b0 || frameDone !== 1'b0) act = 1'b1;
      end
      total++; if (act !== 1'b0) $display("FAIL reset_quiet: activity seen %b want 0", act); else passed++;
   endtask

   task automatic test_single_bin();
      rgb_in = '0; counts = '0;
      rgb_in[0] = 24'hFF0000; counts[0] = 6'd50;
      run_frame(0);
      n = 0;
      for (int i = 0; i < 50; i++) if (pix[i] !== 24'h00FF00) n++;
      total++; if (busy1 !== 1'b1) $display("FAIL single_busy_load: got %b want 1", busy1); else passed++;
      total++; if (first_rise !== 2) $display("FAIL single_first_rise: got %0d want 2", first_rise); else passed++;
      total++; if (nbits !== BITS) $display("FAIL single_bits: got %0d want %0d", nbits, BITS); else passed++;
      total++; if (n !== 0) $display("FAIL single_pixels: pix0=%h bad=%0d want 00ff00", pix[0], n); else passed++;
      total++; if (bad_hi !== 0) $display("FAIL single_high_width: bad=%0d want 0", bad_hi); else passed++;
      total++; if (bad_per !== 0) $display("FAIL single_period: bad=%0d want 0", bad_per); else passed++;
      total++; if (done_cyc - (last_rise + 13) !== 800) $display("FAIL single_latch: got %0d want 800", done_cyc - (last_rise + 13)); else passed++;
      total++; if (done_cyc !== 16402) $display("FAIL single_done_cycle: got %0d want 16402", done_cyc); else passed++;
   endtask

   // Underfill frame with a mid-frame data_v carrying the overfill pattern, then that pattern back-to-back.
   task automatic test_back_to_back();
      rgb_in = '0; counts = '0;
      rgb_in[3] = 24'h0000FF; counts[3] = 6'd10;
      run_frame(3000);
      n = 0;
      for (int i = 0; i < 50; i++) if (pix[i] !== (i < 10 ? 24'h0000FF : 24'h0)) n++;
      total++; if (n !== 0) $display("FAIL under_pixels: pix0=%h pix10=%h bad=%0d", pix[0], pix[10], n); else passed++;
      total++; if (nbits !== BITS) $display("FAIL under_bits: got %0d want %0d", nbits, BITS); else passed++;
      total++; if (done_cyc !== 16402) $display("FAIL under_done_cycle: got %0d want 16402", done_cyc); else passed++;
      run_frame(0);
      n = 0;
      for (int i = 0; i < 50; i++) if (pix[i] !== 24'(i / 10)) n++;
      total++; if (first_rise !== 2) $display("FAIL b2b_first_rise: got %0d want 2", first_rise); else passed++;
      total++; if (n !== 0) $display("FAIL over_pixels: pix10=%h pix49=%h bad=%0d", pix[10], pix[49], n); else passed++;
      total++; if (nbits !== BITS) $display("FAIL over_bits: got %0d want %0d", nbits, BITS); else passed++;
      total++; if (bad_hi !== 0 || bad_per !== 0) $display("FAIL over_timing: hi=%0d per=%0d want 0 0", bad_hi, bad_per); else passed++;
      total++; if (done_cyc - (last_rise + 13) !== 800) $display("FAIL over_latch: got %0d want 800", done_cyc - (last_rise + 13)); else passed++;
   endtask

   task automatic test_reset_mid_frame();
      int rises;
      logic pv, hit, act;
      rgb_in = '0; counts = '0;
      rgb_in[0] = 24'hFF0000; counts[0] = 6'd50;
      data_v = 1'b1;
      rises = 0; pv = 1'b0; hit = 1'b0;
      for (int cyc = 1; cyc <= 9000 && !hit; cyc++) begin
         @(negedge clk);
         data_v = 1'b0;
         if (ledData && !pv) rises++;
         pv = ledData;
         if (rises == 601) hit = 1'b1;
      end
      total++; if (hit !== 1'b1) $display("FAIL mid_reach_bit600: got %b want 1", hit); else passed++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (ledData !== 1'b0) $display("FAIL mid_reset_led: got %b want 0", ledData); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", busy); else passed++;
      act = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (ledData !== 1'b0 || busy !== 1'b0) act = 1'b1;
      end
      total++; if (act !== 1'b0) $display("FAIL mid_no_resume: activity %b want 0", act); else passed++;
   endtask

   initial begin
      test_reset();
      test_single_bin();
      test_back_to_back();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
